// File: rtl/inst_fetch_queue.sv
// Fetch stage: sequential address generation, credit-limited imem requests,
// and a response FIFO tagged with PCs that feeds decode. A redirect flushes the FIFO and drops stale responses.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE, REQ} state_e;

  state_e         state_q, state_d;
  logic [31:0]    req_addr_q, req_addr_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]  outst_q, outst_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [31:0]    inst_mem_q [DEPTH];
  logic [31:0]    inst_mem_d [DEPTH];
  logic [31:0]    pc_mem_q [DEPTH];
  logic [31:0]    pc_mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    pcf_q [DEPTH];
  logic [31:0]    pcf_d [DEPTH];
  logic [AW-1:0]  pcf_wr_q, pcf_wr_d, pcf_rd_q, pcf_rd_d;

  logic           accept, pending, rsp_ok, drop_rsp, push, pop, credit_ok;
  logic [CW:0]    inflight;
  logic [31:0]    target_pc, start_pc;
  logic           unused_bits;

  assign accept    = (state_q == REQ) && imem_req_ready;
  assign pending   = (state_q == REQ) && !imem_req_ready;
  assign rsp_ok    = imem_rsp_valid && (outst_q != '0);
  assign drop_rsp  = (drop_q != '0) || redirect_valid;
  assign push      = rsp_ok && !drop_rsp;
  assign pop       = (count_q != '0) && inst_ready;
  assign inflight  = {1'b0, outst_q} + {1'b0, count_q};
  assign credit_ok = inflight < (CW+1)'(DEPTH);
  assign target_pc = {redirect_pc[31:2], 2'b00};
  assign start_pc  = redirect_valid ? target_pc : fetch_pc_q;
  assign unused_bits = ^redirect_pc[1:0];

  // fetch_pc always names the next address to issue, so it advances when a request is launched
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    fetch_pc_d = start_pc;
    case (state_q)
      IDLE: begin
        if (!halt && credit_ok) begin
          state_d    = REQ;
          req_addr_d = start_pc;
          fetch_pc_d = start_pc + 32'd4;
        end
      end
      REQ: begin
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    if (accept) outst_d = outst_d + CW'(1);
    if (rsp_ok) outst_d = outst_d - CW'(1);
    drop_d = drop_q;
    if (redirect_valid)
      drop_d = outst_d + CW'(pending);
    else if (rsp_ok && (drop_q != '0))
      drop_d = drop_q - CW'(1);
  end

  // PC side-FIFO pairs each response with the address it was fetched from
  always_comb begin
    pcf_d    = pcf_q;
    pcf_wr_d = pcf_wr_q;
    pcf_rd_d = pcf_rd_q;
    if (accept) begin
      pcf_d[pcf_wr_q] = req_addr_q;
      pcf_wr_d        = pcf_wr_q + AW'(1);
    end
    if (rsp_ok) pcf_rd_d = pcf_rd_q + AW'(1);
  end

  always_comb begin
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        inst_mem_d[wr_ptr_q] = imem_rsp_data;
        pc_mem_d[wr_ptr_q]   = pcf_q[pcf_rd_q];
        wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      inst_mem_q <= '{default: '0};
      pc_mem_q   <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pcf_q      <= '{default: '0};
      pcf_wr_q   <= '0;
      pcf_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pcf_q      <= pcf_d;
      pcf_wr_q   <= pcf_wr_d;
      pcf_rd_q   <= pcf_rd_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = req_addr_q;
  assign inst_valid     = (count_q != '0);
  assign inst           = inst_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign inst_pc        = inst_valid ? pc_mem_q[rd_ptr_q] : '0;

  rsp_without_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (outst_q != '0));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a memory responder, a decode-side monitor,
// and directed phases covering streaming, backpressure, request stalls, redirects, halt and PC wrap.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_inst_valid;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;

  always #5 clk = ~clk;

  inst_fetch_queue #(.RESET_PC(32'h8000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  // Second instance only exercises address wrap-around from the top of the address space
  inst_fetch_queue #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .halt(1'b0),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .inst_valid(w_inst_valid), .inst_ready(1'b0), .inst(w_inst), .inst_pc(w_inst_pc)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] expQ[$];
  logic [31:0] accLog[$];
  logic [31:0] rspQ[$];
  logic [31:0] wrapLog[$];
  logic        readyEn = 1'b1;
  logic        rspHold = 1'b0;

  function automatic logic [31:0] romWord(input logic [31:0] pc);
    case (pc[4:2])
      3'd0: return 32'h0000_0413;
      3'd1: return 32'h0010_0493;
      3'd2: return 32'h0020_0513;
      3'd3: return 32'h0030_0593;
      3'd4: return 32'h0040_0613;
      3'd5: return 32'h0050_0693;
      3'd6: return 32'h0060_0713;
      default: return 32'h0070_0793;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic h, input logic ir);
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    inst_ready     = ir;
  endtask

  task automatic expectInst(input logic [31:0] pc);
    expQ.push_back({pc, romWord(pc)});
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic waitAccepts(input int target, input int limit);
    int n = 0;
    while (accLog.size() < target && n < limit) begin
      step();
      n++;
    end
    checkOutput("accept_count", 64'(accLog.size()), 64'(target));
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 40) begin
      step();
      n++;
    end
    repeat (4) step();
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
    checkOutput("halt_no_req", 64'(imem_req_valid), 64'd0);
  endtask

  // Memory model: one response per cycle, the cycle after acceptance unless held
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
      end else begin
        if (rspQ.size() != 0 && !rspHold) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = romWord(rspQ.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = 32'h0;
        end
        imem_req_ready = readyEn;
        if (imem_req_valid && imem_req_ready) begin
          accLog.push_back(imem_req_addr);
          rspQ.push_back(imem_req_addr);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && w_req_valid) wrapLog.push_back(w_req_addr);
    end
  end

  // Decode-side monitor; an instruction presented in a redirect cycle is killed, not consumed
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_inst: got pc=%h inst=%h, required no instruction", inst_pc, inst);
        end else begin
          exp = expQ.pop_front();
          checkOutput("decode_inst", {inst_pc, inst}, exp);
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int c;
    int n;
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) step();
    $display("[TB] reset state");
    checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("rst_req_addr", 64'(imem_req_addr), 64'd0);
    checkOutput("rst_inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("rst_inst", 64'(inst), 64'd0);
    checkOutput("rst_inst_pc", 64'(inst_pc), 64'd0);
    rst_n = 1'b1;
    step();
    checkOutput("first_req_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("first_req_addr", 64'(imem_req_addr), 64'h8000_0000);

    $display("[TB] decode backpressure limits fetches to DEPTH");
    repeat (12) step();
    checkOutput("bp_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("bp_accepts", 64'(accLog.size()), 64'd2);
    checkOutput("bp_inst_valid", 64'(inst_valid), 64'd1);
    checkOutput("bp_head", {inst_pc, inst}, {32'h8000_0000, 32'h0000_0413});
    repeat (3) step();
    checkOutput("bp_head_stable", {inst_pc, inst}, {32'h8000_0000, 32'h0000_0413});

    $display("[TB] streaming then halt");
    for (int i = 0; i < 6; i++) expectInst(32'h8000_0000 + 32'(4 * i));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    waitAccepts(6, 60);
    halt = 1'b1;
    for (int i = 0; i < 6; i++) checkOutput("stream_addr", 64'(accLog[i]), 64'(32'h8000_0000 + 32'(4 * i)));
    drain();

    $display("[TB] request held while memory not ready");
    c = accLog.size();
    readyEn = 1'b0;
    halt = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!imem_req_valid && n < 10);
    for (int i = 0; i < 3; i++) begin
      checkOutput("held_valid", 64'(imem_req_valid), 64'd1);
      checkOutput("held_addr", 64'(imem_req_addr), 64'h8000_0018);
      step();
    end
    readyEn = 1'b1;
    expectInst(32'h8000_0018);
    waitAccepts(c + 1, 10);
    halt = 1'b1;
    drain();
    checkOutput("single_accept", 64'(accLog.size()), 64'(c + 1));

    $display("[TB] redirect with two outstanding");
    c = accLog.size();
    rspHold = 1'b1;
    halt = 1'b0;
    waitAccepts(c + 2, 20);
    repeat (3) step();
    checkOutput("credit_stall", 64'(imem_req_valid), 64'd0);
    applyStimulus(1'b1, 32'h8000_0103, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    rspHold = 1'b0;
    expectInst(32'h8000_0100);
    waitAccepts(c + 3, 30);
    halt = 1'b1;
    checkOutput("redir_addr", 64'(accLog[c + 2]), 64'h8000_0100);
    drain();

    $display("[TB] redirect with pending request and same-cycle response");
    c = accLog.size();
    rspHold = 1'b1;
    halt = 1'b0;
    waitAccepts(c + 1, 20);
    readyEn = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!imem_req_valid && n < 10);
    checkOutput("pending_addr", 64'(imem_req_addr), 64'h8000_0108);
    rspHold = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!imem_rsp_valid && n < 5);
    checkOutput("rsp_seen", 64'(imem_rsp_valid), 64'd1);
    applyStimulus(1'b1, 32'h8000_0200, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    readyEn = 1'b1;
    expectInst(32'h8000_0200);
    waitAccepts(c + 3, 30);
    halt = 1'b1;
    checkOutput("stale_addr", 64'(accLog[c]), 64'h8000_0104);
    checkOutput("redir2_addr", 64'(accLog[c + 2]), 64'h8000_0200);
    drain();

    $display("[TB] address wrap");
    checkOutput("wrap_count", 64'(wrapLog.size()), 64'd2);
    checkOutput("wrap_first", 64'(wrapLog[0]), 64'hFFFF_FFFC);
    checkOutput("wrap_second", 64'(wrapLog[1]), 64'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
